// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster, strobe and look-ahead fetch outputs of vga_timing_gen.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
  parameter int CW = 11
);
  logic          hsync;
  logic          vsync;
  logic          blank_b;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          line_start;
  logic          frame_start;
  logic          req_valid;
  logic [CW-1:0] req_x;
  logic [CW-1:0] req_y;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
  modport master (output hsync, vsync, blank_b, hcnt, vcnt, line_start, frame_start,
                  req_valid, req_x, req_y, frame_cnt);
  modport slave  (input hsync, vsync, blank_b, hcnt, vcnt, line_start, frame_start,
                  req_valid, req_x, req_y, frame_cnt);
`else
  modport master (output hsync, vsync, blank_b, hcnt, vcnt, line_start, frame_start,
                  req_valid, req_x, req_y);
  modport slave  (input hsync, vsync, blank_b, hcnt, vcnt, line_start, frame_start,
                  req_valid, req_x, req_y);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with a look-ahead fetch position.
// Define VGA_FRAME_CNT_EN to build the 16-bit frame_cnt output.
module vga_timing_gen #(
  parameter int CW        = 11,
  parameter int HACTIVE   = 640,
  parameter int HFP       = 16,
  parameter int HSYN      = 96,
  parameter int HBP       = 48,
  parameter int VACTIVE   = 480,
  parameter int VFP       = 10,
  parameter int VSYN      = 2,
  parameter int VBP       = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int LEAD      = 2
) (
  input  logic             vgaclk,
  input  logic             reset_n,
  input  logic             en,
  vga_timing_gen_if.master vif
);
  localparam int HTOTAL = HACTIVE + HFP + HSYN + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSYN + VBP;

  if (HTOTAL > (1 << CW) || VTOTAL > (1 << CW)) begin : g_bad_total
    $error("vga_timing_gen: HTOTAL or VTOTAL does not fit in CW bits");
  end
  if (LEAD < 1 || LEAD > HTOTAL - 1) begin : g_bad_lead
    $error("vga_timing_gen: LEAD must lie in 1..HTOTAL-1");
  end

  localparam logic [CW-1:0] H_LAST = CW'(HTOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(VTOTAL - 1);
  localparam logic [CW-1:0] X_RST  = CW'(LEAD);

  function automatic logic in_rng(input logic [CW-1:0] p, input int lo, input int hi);
    return int'(p) >= lo && int'(p) < hi;
  endfunction

  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
  logic          ls_q, ls_d, fs_q, fs_d, rv_q, rv_d;
  logic          h_wrap, x_wrap;

  // Outputs are decoded from the next counter values so they register on the same edge.
  always_comb begin
    h_wrap  = hcnt_q == H_LAST;
    x_wrap  = x_q == H_LAST;
    hcnt_d  = h_wrap ? '0 : hcnt_q + CW'(1);
    vcnt_d  = h_wrap ? (vcnt_q == V_LAST ? '0 : vcnt_q + CW'(1)) : vcnt_q;
    x_d     = x_wrap ? '0 : x_q + CW'(1);
    y_d     = x_wrap ? (y_q == V_LAST ? '0 : y_q + CW'(1)) : y_q;
    hsync_d = in_rng(hcnt_d, HACTIVE + HFP, HACTIVE + HFP + HSYN) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = in_rng(vcnt_d, VACTIVE + VFP, VACTIVE + VFP + VSYN) ? VSYNC_POL : ~VSYNC_POL;
    blank_d = in_rng(hcnt_d, 0, HACTIVE) && in_rng(vcnt_d, 0, VACTIVE);
    ls_d    = hcnt_d == '0;
    fs_d    = ls_d && vcnt_d == '0;
    rv_d    = in_rng(x_d, 0, HACTIVE) && in_rng(y_d, 0, VACTIVE);
  end

  always_ff @(posedge vgaclk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      x_q     <= X_RST;
      y_q     <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      blank_q <= 1'b1;
      ls_q    <= 1'b1;
      fs_q    <= 1'b1;
      rv_q    <= LEAD < HACTIVE;
    end else if (en) begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      blank_q <= blank_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      rv_q    <= rv_d;
    end
  end

  assign vif.hcnt        = hcnt_q;
  assign vif.vcnt        = vcnt_q;
  assign vif.req_x       = x_q;
  assign vif.req_y       = y_q;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.blank_b     = blank_q;
  assign vif.line_start  = ls_q;
  assign vif.frame_start = fs_q;
  assign vif.req_valid   = rv_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb frame_cnt_d = frame_cnt_q + 16'(h_wrap && vcnt_q == V_LAST);

  always_ff @(posedge vgaclk or negedge reset_n) begin
    if (!reset_n) frame_cnt_q <= '0;
    else if (en)  frame_cnt_q <= frame_cnt_d;
  end

  assign vif.frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three vga_timing_gen instances (default, wide/positive-sync, tiny with random en)
// checked every cycle against a model computed from the count of enabled cycles, plus directed checks.
module tb_vga_timing_gen;
  typedef struct {int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, lead; bit hp, vp;} cfg_t;

  cfg_t cd = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0};
  cfg_t cb = '{800, 40, 128, 88, 480, 10, 2, 33, 4, 1'b1, 1'b1};
  cfg_t cm = '{8, 2, 3, 3, 6, 1, 2, 2, 3, 1'b1, 1'b0};

  logic   vgaclk = 1'b0;
  logic   reset_n = 1'b1;
  logic   en_d = 1'b0, en_b = 1'b0, en_s = 1'b0, en_run = 1'b0, chk_on = 1'b0;
  longint t_d = 0, t_b = 0, t_m = 0;
  int     n_checks = 0, n_errors = 0;
  logic [15:0] fc_d, fc_b, fc_m;

  vga_timing_gen_if #(.CW(11)) vd ();
  vga_timing_gen_if #(.CW(11)) vb ();
  vga_timing_gen_if #(.CW(11)) vm ();

  vga_timing_gen #(.CW(11)) u_d (.vgaclk(vgaclk), .reset_n(reset_n), .en(en_d), .vif(vd));
  vga_timing_gen #(.CW(11), .HACTIVE(800), .HFP(40), .HSYN(128), .HBP(88),
                   .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .LEAD(4))
    u_b (.vgaclk(vgaclk), .reset_n(reset_n), .en(en_b), .vif(vb));
  vga_timing_gen #(.CW(11), .HACTIVE(8), .HFP(2), .HSYN(3), .HBP(3), .VACTIVE(6), .VFP(1),
                   .VSYN(2), .VBP(2), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .LEAD(3))
    u_m (.vgaclk(vgaclk), .reset_n(reset_n), .en(en_s), .vif(vm));

`ifdef VGA_FRAME_CNT_EN
  assign fc_d = vd.frame_cnt;
  assign fc_b = vb.frame_cnt;
  assign fc_m = vm.frame_cnt;
`else
  assign fc_d = '0;
  assign fc_b = '0;
  assign fc_m = '0;
`endif

  always #5 vgaclk = ~vgaclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  initial forever begin
    @(negedge vgaclk);
    en_s = en_run ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // The reference position is just the number of enabled edges since reset.
  always @(posedge vgaclk or negedge reset_n) begin
    if (!reset_n) begin
      t_d <= 0;
      t_b <= 0;
      t_m <= 0;
    end else begin
      if (en_d) t_d <= t_d + 1;
      if (en_b) t_b <= t_b + 1;
      if (en_s) t_m <= t_m + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_dut(input string n, input cfg_t c, input longint t,
                           input logic hs, input logic vs, input logic bl,
                           input logic [10:0] hc, input logic [10:0] vc,
                           input logic ls, input logic fs, input logic rv,
                           input logic [10:0] rx, input logic [10:0] ry, input logic [15:0] fc);
    longint ht, vt, h, v, x, y;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    h  = t % ht;
    v  = (t / ht) % vt;
    x  = (t + c.lead) % ht;
    y  = ((t + c.lead) / ht) % vt;
    check({n, ".hcnt"}, 64'(hc), 64'(h));
    check({n, ".vcnt"}, 64'(vc), 64'(v));
    check({n, ".hsync"}, 64'(hs),
          64'((h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) ? c.hp : !c.hp));
    check({n, ".vsync"}, 64'(vs),
          64'((v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) ? c.vp : !c.vp));
    check({n, ".blank_b"}, 64'(bl), 64'(h < c.ha && v < c.va));
    check({n, ".line_start"}, 64'(ls), 64'(h == 0));
    check({n, ".frame_start"}, 64'(fs), 64'(h == 0 && v == 0));
    check({n, ".req_x"}, 64'(rx), 64'(x));
    check({n, ".req_y"}, 64'(ry), 64'(y));
    check({n, ".req_valid"}, 64'(rv), 64'(x < c.ha && y < c.va));
`ifdef VGA_FRAME_CNT_EN
    check({n, ".frame_cnt"}, 64'(fc), 64'((t / (ht * vt)) % 65536));
`else
    if (fc != 16'd0) check({n, ".frame_cnt"}, 64'(fc), 64'd0);
`endif
  endtask

  always @(negedge vgaclk) begin
    if (chk_on) begin
      check_dut("d", cd, t_d, vd.hsync, vd.vsync, vd.blank_b, vd.hcnt, vd.vcnt, vd.line_start,
                vd.frame_start, vd.req_valid, vd.req_x, vd.req_y, fc_d);
      check_dut("b", cb, t_b, vb.hsync, vb.vsync, vb.blank_b, vb.hcnt, vb.vcnt, vb.line_start,
                vb.frame_start, vb.req_valid, vb.req_x, vb.req_y, fc_b);
      check_dut("m", cm, t_m, vm.hsync, vm.vsync, vm.blank_b, vm.hcnt, vm.vcnt, vm.line_start,
                vm.frame_start, vm.req_valid, vm.req_x, vm.req_y, fc_m);
    end
  end

  task automatic wait_h(input int h);
    int k = 0;
    while (int'(vd.hcnt) != h && k < 2000) begin
      @(negedge vgaclk);
      k++;
    end
    if (k == 2000) check("wait_hcnt", 64'(vd.hcnt), 64'(h));
  endtask

  task automatic check_default_reset(input string n);
    check({n, ".hcnt"}, 64'(vd.hcnt), 64'd0);
    check({n, ".vcnt"}, 64'(vd.vcnt), 64'd0);
    check({n, ".hsync"}, 64'(vd.hsync), 64'd1);
    check({n, ".vsync"}, 64'(vd.vsync), 64'd1);
    check({n, ".blank_b"}, 64'(vd.blank_b), 64'd1);
    check({n, ".line_start"}, 64'(vd.line_start), 64'd1);
    check({n, ".frame_start"}, 64'(vd.frame_start), 64'd1);
    check({n, ".req_x"}, 64'(vd.req_x), 64'd2);
    check({n, ".req_y"}, 64'(vd.req_y), 64'd0);
    check({n, ".req_valid"}, 64'(vd.req_valid), 64'd1);
  endtask

  initial begin
    int n, first, last, maxh, k;
    logic [10:0] v0;
    logic [21:0] q[$];
    #1 reset_n = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(negedge vgaclk);
    check_default_reset("rst");
    check("rst.b.req_x", 64'(vb.req_x), 64'd4);
    check("rst.b.hsync", 64'(vb.hsync), 64'd0);
    check("rst.b.vsync", 64'(vb.vsync), 64'd0);
    #2 reset_n = 1'b1;
    en_d = 1'b1;
    en_b = 1'b1;
    en_run = 1'b1;

    // Asynchronous reset mid-line, observed before any clock edge.
    wait_h(300);
    #2 reset_n = 1'b0;
    #1 check_default_reset("mid_rst");
    @(negedge vgaclk);
    #2 reset_n = 1'b1;
    @(posedge vgaclk);
    #1 check("rel.hcnt", 64'(vd.hcnt), 64'd1);

    // One line tail: blank edge, hsync pulse, look-ahead and wrap.
    wait_h(638);
    v0 = vd.vcnt;
    n = 0;
    first = -1;
    last = -1;
    for (int i = 0; i < 163; i++) begin
      if (vd.hcnt == 11'd638) begin
        check("pf638.req_x", 64'(vd.req_x), 64'd640);
        check("pf638.req_valid", 64'(vd.req_valid), 64'd0);
      end
      if (vd.hcnt == 11'd639) check("h639.blank_b", 64'(vd.blank_b), 64'd1);
      if (vd.hcnt == 11'd640) check("h640.blank_b", 64'(vd.blank_b), 64'd0);
      if (vd.hcnt == 11'd798) begin
        check("pf798.req_x", 64'(vd.req_x), 64'd0);
        check("pf798.req_y", 64'(vd.req_y), 64'(v0 + 11'd1));
      end
      if (vd.hcnt == 11'd0) begin
        check("wrap.vcnt", 64'(vd.vcnt), 64'(v0 + 11'd1));
        check("wrap.line_start", 64'(vd.line_start), 64'd1);
      end
      if (!vd.hsync) begin
        n++;
        if (first < 0) first = int'(vd.hcnt);
        last = int'(vd.hcnt);
      end
      q.push_back({vd.req_y, vd.req_x});
      if (q.size() == 3) check("pf.lead2", 64'(q.pop_front()), 64'({vd.vcnt, vd.hcnt}));
      @(negedge vgaclk);
    end
    check("hs.len", 64'(n), 64'd96);
    check("hs.first", 64'(first), 64'd656);
    check("hs.last", 64'(last), 64'd751);

    // Freeze with en low for five cycles at hcnt=100.
    wait_h(100);
    en_d = 1'b0;
    repeat (5) begin
      @(negedge vgaclk);
      check("frz.hcnt", 64'(vd.hcnt), 64'd100);
      check("frz.req_x", 64'(vd.req_x), 64'd102);
      check("frz.blank_b", 64'(vd.blank_b), 64'd1);
      check("frz.hsync", 64'(vd.hsync), 64'd1);
    end
    en_d = 1'b1;
    @(negedge vgaclk);
    check("frz.resume", 64'(vd.hcnt), 64'd101);

    // Wide instance with positive sync polarity: one full line.
    k = 0;
    while (vb.hcnt != 11'd0 && k < 2000) begin
      @(negedge vgaclk);
      k++;
    end
    check("b.line0", 64'(vb.hcnt), 64'd0);
    first = -1;
    last = -1;
    maxh = 0;
    for (int i = 0; i < 1056; i++) begin
      if (vb.hsync) begin
        if (first < 0) first = int'(vb.hcnt);
        last = int'(vb.hcnt);
      end
      if (int'(vb.hcnt) > maxh) maxh = int'(vb.hcnt);
      @(negedge vgaclk);
    end
    check("b.hs_first", 64'(first), 64'd840);
    check("b.hs_last", 64'(last), 64'd967);
    check("b.hmax", 64'(maxh), 64'd1055);
    check("b.wrap", 64'(vb.hcnt), 64'd0);

    // Tiny instance with en held high: frame_start recurs every 16*11 cycles.
    en_run = 1'b0;
    @(negedge vgaclk);
    #2 reset_n = 1'b0;
    @(negedge vgaclk);
    #2 reset_n = 1'b1;
    #1 check("m.fs0", 64'(vm.frame_start), 64'd1);
`ifdef VGA_FRAME_CNT_EN
    check("m.fc0", 64'(vm.frame_cnt), 64'd0);
`endif
    repeat (176) @(posedge vgaclk);
    @(negedge vgaclk);
    check("m.fs1", 64'(vm.frame_start), 64'd1);
    check("m.fs1.hv", 64'({vm.vcnt, vm.hcnt}), 64'd0);
`ifdef VGA_FRAME_CNT_EN
    check("m.fc1", 64'(vm.frame_cnt), 64'd1);
`endif
    repeat (175) @(negedge vgaclk);
    check("m.fs_mid", 64'(vm.frame_start), 64'd0);
    @(negedge vgaclk);
    check("m.fs2", 64'(vm.frame_start), 64'd1);
`ifdef VGA_FRAME_CNT_EN
    check("m.fc2", 64'(vm.frame_cnt), 64'd2);
`endif
    @(negedge vgaclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
